lw_wb_queue: RTL
================

Name: lw_wb_queue

Overview:
- Parametrised successor to the single-entry load-writeback pipeline register.
- Buffers up to DEPTH load results (dst reg, ROB/RS tag, data) between the load execute/memory stage and the CDB/register-file writeback port.
- Presents the oldest entry with valid/ready handshaking so loads are not lost when the writeback arbiter stalls.
- Supports a pipeline flush on mispredict or exception.

Parameters:
- DATA_W, 32, width of load data.
- REG_W, 5, width of destination register index.
- TAG_W, 5, width of rename/ROB tag.
- DEPTH, 4, number of entries; must be a power of two and ≥ 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  load result present (replaces we_EX).
- in_ready  out  1  queue can accept this cycle.
- in_dst  in  REG_W  destination register.
- in_tag  in  TAG_W  producer tag.
- in_data  in  DATA_W  load data.
- out_valid  out  1  head entry valid (writeback enable).
- out_ready  in  1  writeback port grant.
- out_dst  out  REG_W  head destination.
- out_tag  out  TAG_W  head tag.
- out_data  out  DATA_W  head data.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - Pointers and count go to 0; out_valid=0.
  - out_dst, out_tag, out_data = 0; in_ready=1 once reset releases.
  - Storage contents need not be cleared.
- Storage and pointers:
  - Circular buffer of DEPTH entries.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
  - count is held as an explicit register.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It depends only on state, never combinationally on out_ready.
  - Consequence: when full, no push is accepted even if a pop occurs in the same cycle.
- Latency:
  - An entry pushed at edge N is visible on out_* with out_valid=1 after edge N (one cycle), matching the register it replaces.
  - No combinational in→out path.
- Outputs:
  - out_valid = (count != 0).
  - When out_valid=1, out_* show the head entry.
  - When out_valid=0, out_dst, out_tag and out_data are forced to 0 so downstream never sees stale writes.
- Hold rule: while out_valid=1 and out_ready=0, out_* stay stable every cycle.
- Simultaneous push and pop (0 < count < DEPTH): both take effect, count is unchanged, order is preserved.
- Count update: count next = count + push − pop. Overflow and underflow cannot occur by construction.
- Order: strict FIFO; entries leave in arrival order.
- Flush:
  - Highest priority.
  - Pointers and count go to 0 at the next edge; out_valid=0 after that edge.
  - A push or pop presented in the flush cycle is discarded and has no effect.
- Inputs ignored while in_ready=0; the producer must hold them.
- All outputs are registered state or decoded only from registered state.

Test Plan:
- Reset, then rst held low with random inputs → out_valid=0, out_dst/out_tag/out_data=0, count=0. After release → in_ready=1.
- Single load dst=7, tag=3, data=0xDEADBEEF, out_ready=1 → next cycle out_valid=1 with those values. Following cycle out_valid=0, outputs 0, count=0.
- out_ready=0, push 5 loads (DEPTH=4) → count reaches 4, in_ready=0, and the 5th load is not accepted. out_* hold the first load throughout. Release out_ready → 4 loads drain in order, then the held 5th is accepted.
- Continuous push and pop with count=2 for 10 cycles → count stays 2, the output sequence equals the input sequence, and pointers wrap past DEPTH−1 correctly.
- Count=3, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, and neither the pushed entry nor a pop is observed.
- rst asserted asynchronously mid-cycle while full → out_valid drops to 0 immediately, before the next clk edge. After release the queue is empty and accepts new loads.

Source files
------------

// File: rtl/lw_wb_queue.sv
// Load-writeback FIFO: buffers load results for the writeback port. An entry is visible one cycle after its push.
// in_ready depends only on occupancy, so a full queue refuses a push even when a pop happens in the same cycle.
module lw_wb_queue #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_dst,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  out_dst,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  entry_t           head;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Empty queue drives zeros so writeback never sees a stale entry.
  assign head     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_dst  = head.dst;
  assign out_tag  = head.tag;
  assign out_data = head.data;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= '{dst: in_dst, tag: in_tag, data: in_data};
    end
  end
endmodule
